// File: rtl/serial_adder.sv
// Bit-serial adder: accepts a/b/cin, adds one bit per cycle LSB first,
// then holds {cout,sum} until the consumer takes it.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] res_shift;

  // Full-adder slice on the current LSBs and the running carry.
  always_comb begin
    bit_s     = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
    bit_c     = (a_sr_q[0] & b_sr_q[0]) |
                (c_q & (a_sr_q[0] ^ b_sr_q[0]));
    res_shift = {bit_s, res_q[WIDTH-1:1]};
  end

  // Next-state and datapath control for IDLE/ADD/HOLD.
  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    res_d       = res_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    c_d         = c_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          c_d     = cin;
          cnt_d   = '0;
          state_d = ADD;
          busy_d  = 1'b1;
        end
      end
      ADD: begin
        c_d    = bit_c;
        res_d  = res_shift;
        a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d     = HOLD;
          sum_d       = res_shift;
          cout_d      = bit_c;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          cnt_d       = '0;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      res_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      c_q         <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      res_q       <= res_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      c_q         <= c_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Ready depends only on state and reset, never on in_valid.
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = out_valid_q;
    sum       = sum_q;
    cout      = cout_q;
    busy      = busy_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder, WIDTH=8.
// Drives inputs #1 after posedge and samples there as well.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       busy;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one operand set, wait for result, check latency and value.
  task automatic do_op(input string tag, input logic [7:0] xa,
                       input logic [7:0] xb, input logic xc,
                       input logic [7:0] es, input logic ec);
    int n;
    a = xa; b = xb; cin = xc; in_valid = 1'b1;
    chk({tag, "_rdy"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, n, 8);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_hold_rdy"}, in_ready, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ov_fall"}, out_valid, 0);
    chk({tag, "_rdy_back"}, in_ready, 1);
    chk({tag, "_keep_sum"}, sum, es);
  endtask

  logic [8:0] q[$];
  logic [8:0] exp9;
  int         nres;
  int         n;
  logic [7:0] ea [3];
  logic [7:0] eb [3];
  logic [7:0] es [3];
  logic       ec [3];
  logic       seen_ov;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    step();
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);

    do_op("op0f01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
    do_op("opff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    do_op("opffff1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    do_op("op3c5a1", 8'h3C, 8'h5A, 1'b1, 8'h97, 1'b0);

    // Backpressure with junk on the inputs.
    a = 8'h12; b = 8'h34; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("bp_lat", n, 8);
    for (int i = 0; i < 5; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      in_valid = i[0];
      step();
      chk("bp_sum", sum, 8'h47);
      chk("bp_cout", cout, 0);
      chk("bp_ov", out_valid, 1);
      chk("bp_rdy", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_ov_fall", out_valid, 0);
    chk("bp_rdy_back", in_ready, 1);

    // Reset in the 4th ADD cycle aborts the operation.
    a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("ab_ov", out_valid, 0);
    chk("ab_sum", sum, 0);
    chk("ab_cout", cout, 0);
    chk("ab_busy", busy, 0);
    chk("ab_rdy", in_ready, 1);
    seen_ov = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      seen_ov = seen_ov | out_valid;
    end
    chk("ab_no_result", seen_ov, 0);

    // Back-to-back with in_valid and out_ready held high.
    ea = '{8'h01, 8'h80, 8'h7F};
    eb = '{8'h02, 8'h80, 8'h01};
    es = '{8'h03, 8'h00, 8'h80};
    ec = '{1'b0, 1'b1, 1'b0};
    cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = ea[i]; b = eb[i];
      chk("b2b_rdy", in_ready, 1);
      step();
      n = 0;
      while (!out_valid && n < 20) begin
        chk("b2b_adding", busy, 1);
        step();
        n++;
      end
      chk("b2b_lat", n, 8);
      chk("b2b_sum", sum, es[i]);
      chk("b2b_cout", cout, ec[i]);
      step();
      chk("b2b_idle", in_ready, 1);
      chk("b2b_ov_fall", out_valid, 0);
    end
    in_valid = 1'b0; out_ready = 1'b0;

    // Random handshakes with a scoreboard.
    nres = 0;
    for (int i = 0; i < 3000; i++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (in_valid && in_ready)
        q.push_back(9'(a) + 9'(b) + 9'(cin));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_dup", 1, 0);
        end else begin
          exp9 = q.pop_front();
          chk("rnd_res", {cout, sum}, exp9);
          nres++;
        end
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 30) begin
      #1;
      if (out_valid) begin
        exp9 = q.pop_front();
        chk("rnd_res", {cout, sum}, exp9);
        nres++;
      end
      step();
      n++;
    end
    chk("rnd_drained", q.size(), 0);
    chk("rnd_some", (nres > 100), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
